// File: rtl/led_frame_buffer.sv
// led_frame_buffer: HUB75 pixel store with a bit-plane masked, 2-cycle read port.
// Define LED_FRAME_BUFFER_DOUBLE_BUFFER_EN for tear-free double buffering.
module led_frame_buffer #(
  parameter int COLUMNS    = 64,
  parameter int ROWS_HALF  = 16,
  parameter int COLOR_BITS = 6
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [7:0]              wr_x,
  input  logic [4:0]              wr_y,
  input  logic [3*COLOR_BITS-1:0] wr_rgb,
  input  logic                    wr_commit,
  input  logic [7:0]              column_address,
  input  logic [3:0]              row_address,
  input  logic [COLOR_BITS-1:0]   brightness_mask,
  input  logic                    row_latch,
  output logic [2:0]              rgb1,
  output logic [2:0]              rgb2,
  output logic                    swap_done
);

  // state   | meaning
  // IDLE    | accepting writes, waiting for wr_commit
  // PENDING | commit registered, waiting for the end-of-frame swap point

  localparam int PIX_W  = 3 * COLOR_BITS;
  localparam int COL_W  = $clog2(COLUMNS);
  localparam int ROW_W  = $clog2(ROWS_HALF);
  localparam int ADDR_W = ROW_W + COL_W;
  localparam logic [8:0] COL_LIMIT = 9'(COLUMNS);
  localparam logic [3:0] LAST_ROW  = 4'(ROWS_HALF - 1);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t state_q, state_d;
  logic   swap_point;
  logic   swap_fire;
  logic   ready_q;
  logic   wr_fire;
  logic   wr_in_range;
  logic   wr_top;
  logic   wr_bot;
  logic [ADDR_W-1:0]     wr_addr;
  logic [ADDR_W-1:0]     rd_addr;
  logic [PIX_W-1:0]      top_q;
  logic [PIX_W-1:0]      bot_q;
  logic [COLOR_BITS-1:0] mask_d;
  logic                  col_ok_d;

  function automatic logic [2:0] plane_bits(input logic [PIX_W-1:0]      pix,
                                            input logic [COLOR_BITS-1:0] mask);
    return {|(pix[3*COLOR_BITS-1:2*COLOR_BITS] & mask),
            |(pix[2*COLOR_BITS-1:COLOR_BITS] & mask),
            |(pix[COLOR_BITS-1:0] & mask)};
  endfunction

  // Last bit plane of the last row pair: the frame boundary
  assign swap_point = row_latch && (row_address == LAST_ROW) &&
                      brightness_mask[COLOR_BITS-1];

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    swap_fire = 1'b0;
    case (state_q)
      IDLE:    if (wr_commit) state_d = PENDING;
      PENDING: if (swap_point) begin
        state_d   = IDLE;
        swap_fire = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      ready_q   <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      swap_done <= swap_fire;
    end
  end

  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = {1'b0, wr_x} < COL_LIMIT;
  assign wr_addr     = {wr_y[ROW_W-1:0], wr_x[COL_W-1:0]};
  assign rd_addr     = {row_address[ROW_W-1:0], column_address[COL_W-1:0]};
  assign wr_top      = wr_fire && wr_in_range && !wr_y[4];
  assign wr_bot      = wr_fire && wr_in_range && wr_y[4];

`ifdef LED_FRAME_BUFFER_DOUBLE_BUFFER_EN
  localparam int DEPTH = 2 << ADDR_W;
  logic              display_bank;
  logic [ADDR_W:0]   wr_full;
  logic [ADDR_W:0]   rd_full;

  assign wr_full  = {~display_bank, wr_addr};
  assign rd_full  = {display_bank, rd_addr};
  assign wr_ready = ready_q && (state_q == IDLE);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)          display_bank <= 1'b0;
    else if (swap_fire) display_bank <= ~display_bank;
  end
`else
  localparam int DEPTH = 1 << ADDR_W;
  logic [ADDR_W-1:0] wr_full;
  logic [ADDR_W-1:0] rd_full;

  // Single bank: commit only signals the frame boundary, writes never stall
  assign wr_full  = wr_addr;
  assign rd_full  = rd_addr;
  assign wr_ready = ready_q;
`endif

  logic [PIX_W-1:0] mem_top [DEPTH];
  logic [PIX_W-1:0] mem_bot [DEPTH];

  always_ff @(posedge clk_in) begin
    if (wr_top) mem_top[wr_full] <= wr_rgb;
    if (wr_bot) mem_bot[wr_full] <= wr_rgb;
  end

  // Separate read process keeps read-during-write returning the old word
  always_ff @(posedge clk_in) begin
    top_q <= mem_top[rd_full];
    bot_q <= mem_bot[rd_full];
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      mask_d   <= '0;
      col_ok_d <= 1'b0;
      rgb1     <= 3'b000;
      rgb2     <= 3'b000;
    end else begin
      mask_d   <= brightness_mask;
      col_ok_d <= {1'b0, column_address} < COL_LIMIT;
      rgb1     <= col_ok_d ? plane_bits(top_q, mask_d) : 3'b000;
      rgb2     <= col_ok_d ? plane_bits(bot_q, mask_d) : 3'b000;
    end
  end

endmodule

// File: doc/led_frame_buffer.md
# led_frame_buffer

Pixel store for the 64x32 HUB75 LED matrix that replaces the fixed-pattern generator between the scan generator (`matrix_scan`) and the pin assignments. A write port fills pixels from an upstream loader (UART/SPI bridge). A read port is indexed by the scanner's `column_address`/`row_address` and `brightness_mask`. It returns the bit-plane-masked `rgb1` (top half) and `rgb2` (bottom half) bits, optionally double-buffered so that frame updates are tear-free.

## Interface
- `COLUMNS`, 64: panel width; columns at or above this index are blank.
- `ROWS_HALF`, 16: rows per half-panel; the panel has 2*ROWS_HALF rows.
- `COLOR_BITS`, 6: bits per colour channel; width of `brightness_mask`.
- `clk_in`  in  1  system clock (the same `clk_root` that drives `matrix_scan`).
- `reset`  in  1  asynchronous, active-high reset.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted when `wr_valid && wr_ready` on a rising edge.
- `wr_x`  in  8  write column.
- `wr_y`  in  5  write row. Bit 4 selects the bottom half.
- `wr_rgb`  in  3*COLOR_BITS  pixel value, ordered {blue, green, red}.
- `wr_commit`  in  1  single-cycle pulse meaning "back buffer complete, display it".
- `column_address`  in  8  scan column from the scanner.
- `row_address`  in  4  scan row pair from the scanner.
- `brightness_mask`  in  COLOR_BITS  one-hot bit plane currently shown.
- `row_latch`  in  1  scanner row-latch strobe.
- `rgb1`  out  3  {b,g,r} bits for row `row_address`.
- `rgb2`  out  3  {b,g,r} bits for row `row_address+ROWS_HALF`.
- `swap_done`  out  1  single-cycle pulse when a committed buffer becomes visible.

## Operation
- Storage is split into a top RAM and a bottom RAM, each COLUMNS*ROWS_HALF words of 3*COLOR_BITS bits. Each has one synchronous write port and one synchronous read port. Both halves are read every cycle at {row_address, column_address[5:0]}.
- Writes:
  - `wr_y[4]` selects the RAM; `wr_y[3:0]` and `wr_x` form the address.
  - If `wr_x >= COLUMNS`, the handshake completes but the data is dropped.
- Output bit per channel is `(channel & mask_d) != 0`, where `mask_d` is `brightness_mask` delayed to align with the RAM data.
- Out-of-range read (`column_address >= COLUMNS`): outputs are forced to 3'b000.
- Commit FSM, with DOUBLE_BUFFER_EN defined:
  - IDLE: `wr_ready`=1. `wr_commit` moves to PENDING. A write accepted in the same cycle as `wr_commit` lands in the back bank before the swap.
  - PENDING: `wr_ready`=0 and further `wr_commit` pulses are ignored. Leaves at the swap point: the cycle in which `row_latch`=1, `row_address`=ROWS_HALF-1 and `brightness_mask[COLOR_BITS-1]`=1. On that edge `display_bank` toggles, `swap_done` pulses, and the FSM returns to IDLE.
  - A swap point with no pending commit causes no change.
- Reset:
  - `rgb1`, `rgb2` = 0; `swap_done` = 0; `wr_ready` = 0 while reset is asserted and 1 on the first edge after release.
  - FSM = IDLE; `display_bank` = 0, so bank 1 is the first write target.
  - RAM contents are not cleared.
  - Reset during PENDING discards the commit.

## Timing
- Read latency is exactly 2 `clk_in` cycles. Address/mask presented at edge N gives the RAM output at N+1 and registered `rgb1`/`rgb2` at N+2. The scanner's pixel-clock phase accounts for this fixed latency.
- Write-to-read: a write accepted at edge N to the displayed bank is visible to a read addressed at edge N+1 or later. Read-during-write to the same address returns the old data.
- The swap takes effect for reads addressed on the cycle after the swap edge.
- `swap_done` is high for exactly one cycle, coincident with the bank toggle.
- `wr_ready` falls on the edge that registers `wr_commit` and rises on the swap edge.

## Configuration
- `LED_FRAME_BUFFER_DOUBLE_BUFFER_EN` defined:
  - Two banks per half; writes go to the back bank and reads to `display_bank`.
  - The commit FSM is active as described above.
- Not defined:
  - One bank per half, half the EBR usage; writes go directly to the displayed image and tearing is allowed.
  - `wr_ready` = 1 whenever not in reset.
  - `wr_commit` produces a `swap_done` pulse at the next swap point only, with no bank change and no deassertion of `wr_ready`.

## Test plan
- Write (x=3, y=2, rgb r=6'h20, g=0, b=6'h01), then commit, then wait for a swap point. Scan col 3, row 2 with mask 6'h20 -> `rgb1`=3'b001 two cycles later. Mask 6'h01 -> `rgb1`=3'b100. `rgb2`=0 throughout.
- Write at y=18, x=10 with all channels 6'h3F, commit, swap. Scan col 10, row 2 with any mask -> `rgb2`=3'b111, `rgb1` = stored row-2 value.
- With double buffering: write a back-bank pixel without a commit -> the display still shows the old value. Pulse `wr_commit` mid-frame -> `wr_ready`=0 until the swap point. At the swap point, `swap_done` pulses once and the new value appears on the next read.
- Column out of range: `column_address`=64 and 200 -> `rgb1`=`rgb2`=0. A write with `wr_x`=70 is acknowledged and no RAM word changes.
- Assert reset while PENDING -> `wr_ready`=0 during reset, outputs 0. After release: `wr_ready`=1, `display_bank`=0, no `swap_done` at the next swap point.
- Same-cycle `wr_commit` and write handshake -> that pixel is visible after the swap.
